udma_hyper_eot_tracker: RTL and testbench
=========================================

# udma_hyper_eot_tracker

Multi-channel end-of-transfer classifier for the HyperBus uDMA peripheral. It records the direction (read or write) of every transfer the uDMA channels start, and pairs each controller end-of-transaction pulse with the oldest outstanding direction. It then emits a registered read-EOT or write-EOT event per channel. It sits between the per-channel `UDMA_LIN_CH` event lines, the `evt_eot_hyper_o` output of `udma_hyper_top`, and the peripheral `events_o` vector. It replaces single-bit direction tracking with a per-channel direction FIFO that tolerates queued transfers.

## Interface
- `NB_CH`, 2: number of HyperBus channels (≥1).
- `DEPTH`, 4: direction-FIFO entries per channel; power of two, ≥2.
- `CNT_W`, `$clog2(DEPTH+1)`: derived; width of the occupancy count.

- `sys_clk_i`  in  1  only clock; all state on rising edge.
- `rstn_i`  in  1  asynchronous, active-low reset.
- `rx_evt_i`  in  NB_CH  per-channel RX (read) transfer-start pulse.
- `tx_evt_i`  in  NB_CH  per-channel TX (write) transfer-start pulse.
- `eot_i`  in  NB_CH  per-channel controller end-of-transaction pulse.
- `clr_i`  in  NB_CH  per-channel synchronous flush.
- `eot_rd_o`  out  NB_CH  read-complete event, 1-cycle pulse.
- `eot_wr_o`  out  NB_CH  write-complete event, 1-cycle pulse.
- `pending_o`  out  NB_CH×CNT_W  FIFO occupancy per channel.
- `ovf_o`  out  NB_CH  sticky: push dropped because the FIFO was full.
- `udf_o`  out  NB_CH  sticky: EOT arrived with the FIFO empty.

## Operation
- Channels are fully independent; the rules below apply per channel `c`.
- Each channel has a direction FIFO (1 bit per entry: 1 = read, 0 = write), read/write pointers, an occupancy count, and a `last_dir` register.
- Push condition: `rx_evt_i` or `tx_evt_i` asserted.
  - Tag = 1 if RX only; 0 if TX only.
  - If RX and TX are asserted together, tag = `last_dir` and exactly one entry is pushed.
  - `last_dir` is updated to the pushed tag.
- Pop condition: `eot_i` asserted.
  - FIFO non-empty: pop the head. Head = 1 pulses `eot_rd_o`; head = 0 pulses `eot_wr_o`.
  - FIFO empty with a push in the same cycle: bypass. The incoming tag selects the event, nothing is stored, the count is unchanged, and `udf_o` is not set.
  - FIFO empty with no push: emit an event using `last_dir` and set `udf_o`.
- Push and pop in the same cycle with the FIFO non-empty: both are performed; the count is unchanged. This is legal even when the FIFO is full (no overflow).
- Push with the FIFO full and no pop: the entry is dropped, `ovf_o` is set, and `last_dir` is still updated.
- Pointers wrap modulo `DEPTH`. The count saturates at neither end; the over/underflow rules above prevent it from leaving the range 0..DEPTH.
- `clr_i` takes priority over every same-cycle event on that channel:
  - pointers and count go to 0;
  - `last_dir` goes to 0;
  - `ovf_o` and `udf_o` are cleared;
  - no event is emitted that cycle.
- `eot_rd_o` and `eot_wr_o` are never asserted together.

## Timing
- All outputs are registered.
- Reset values: `eot_rd_o`, `eot_wr_o`, `pending_o`, `ovf_o`, `udf_o` all 0; `last_dir` = 0 (write); FIFO empty.
- Event latency: an `eot_i` in cycle N produces its event pulse in cycle N+1, exactly one cycle wide. Back-to-back `eot_i` pulses produce back-to-back events.
- `pending_o` reflects the pushes and pops of cycle N in cycle N+1.
- `ovf_o` and `udf_o` assert in cycle N+1 and hold until `clr_i` or reset.
- Asynchronous reset mid-operation discards all queued directions immediately; outputs go low without waiting for a clock edge.

## Test plan
- Ordering: ch0 `rx_evt_i`, `tx_evt_i`, `rx_evt_i` in consecutive cycles, then three `eot_i` pulses -> `eot_rd_o`, `eot_wr_o`, `eot_rd_o` on successive cycles, each 1 cycle after its `eot_i`; `pending_o[0]` counts 1,2,3 then 2,1,0.
- Full/overflow, DEPTH=4: five `tx_evt_i` pulses with no `eot_i` -> `pending_o`=4, `ovf_o[0]`=1; four `eot_i` pulses -> four `eot_wr_o` pulses, `pending_o`=0.
- Underflow and bypass: `eot_i` with the FIFO empty after reset -> `eot_wr_o`=1, `udf_o`=1. After `clr_i`, assert `rx_evt_i` and `eot_i` in the same cycle -> `eot_rd_o`=1, `pending_o`=0, `udf_o`=0.
- Simultaneous push/pop at full: FIFO = {R,R,W,W}; assert `tx_evt_i` and `eot_i` together -> `eot_rd_o` pulse, `pending_o` stays 4, `ovf_o`=0; then four pops -> R,W,W,W.
- Channel isolation and clear: interleave random events on ch0 and ch1, with `clr_i[1]` asserted mid-stream together with an `eot_i[1]` -> no event on ch1 that cycle, ch1 count = 0, ch0 sequence matches the scoreboard.
- Reset mid-operation: with 3 entries pending, assert `rstn_i`=0 asynchronously -> all outputs 0 immediately; after release, `eot_i` -> `eot_wr_o`=1 with `udf_o`=1.

Source files
------------

// File: rtl/udma_hyper_eot_tracker_if.sv
// HyperBus uDMA EOT tracker bundle: per-channel transfer-start/EOT strobes
// in, classified read/write completion events and status out.
interface udma_hyper_eot_tracker_if #(
    parameter int NB_CH = 2,
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
);
    logic [NB_CH-1:0]            rx_evt_i;
    logic [NB_CH-1:0]            tx_evt_i;
    logic [NB_CH-1:0]            eot_i;
    logic [NB_CH-1:0]            clr_i;
    logic [NB_CH-1:0]            eot_rd_o;
    logic [NB_CH-1:0]            eot_wr_o;
    logic [NB_CH-1:0][CNT_W-1:0] pending_o;
    logic [NB_CH-1:0]            ovf_o;
    logic [NB_CH-1:0]            udf_o;

    modport master (
        output rx_evt_i, tx_evt_i, eot_i, clr_i,
        input  eot_rd_o, eot_wr_o, pending_o, ovf_o, udf_o
    );

    modport slave (
        input  rx_evt_i, tx_evt_i, eot_i, clr_i,
        output eot_rd_o, eot_wr_o, pending_o, ovf_o, udf_o
    );
endinterface

// File: rtl/udma_hyper_eot_tracker.sv
// Per-channel direction FIFO pairing controller EOT pulses with the oldest
// outstanding uDMA transfer direction; emits registered read/write EOT events.
module udma_hyper_eot_tracker #(
    parameter int NB_CH = 2,
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic                     sys_clk_i,
    input  logic                     rstn_i,
    udma_hyper_eot_tracker_if.slave  bus
);
    localparam int PW = $clog2(DEPTH);

    for (genvar c = 0; c < NB_CH; c++) begin : g_ch
        logic [DEPTH-1:0] r_fifo;
        logic [PW-1:0]    r_rd;
        logic [PW-1:0]    r_wr;
        logic [CNT_W-1:0] r_cnt;
        logic             r_last;
        logic             r_ovf;
        logic             r_udf;
        logic             r_eot_rd;
        logic             r_eot_wr;

        logic w_rx, w_tx, w_eot, w_clr;
        logic w_push, w_tag, w_empty, w_full;
        logic w_pop, w_store, w_ev;

        assign w_rx    = bus.rx_evt_i[c];
        assign w_tx    = bus.tx_evt_i[c];
        assign w_eot   = bus.eot_i[c];
        assign w_clr   = bus.clr_i[c];
        assign w_push  = w_rx | w_tx;
        // Simultaneous RX/TX repeats the previous direction
        assign w_tag   = (w_rx & w_tx) ? r_last : w_rx;
        assign w_empty = (r_cnt == '0);
        assign w_full  = (r_cnt == CNT_W'(DEPTH));
        assign w_pop   = w_eot & ~w_empty;
        // An EOT on an empty FIFO consumes the incoming push directly
        assign w_store = w_push & (w_pop | (~w_eot & ~w_full));
        assign w_ev    = w_pop  ? r_fifo[r_rd] :
                         w_push ? w_tag : r_last;

        always_ff @(posedge sys_clk_i or negedge rstn_i) begin
            if (!rstn_i) begin
                r_fifo   <= '0;
                r_rd     <= '0;
                r_wr     <= '0;
                r_cnt    <= '0;
                r_last   <= 1'b0;
                r_ovf    <= 1'b0;
                r_udf    <= 1'b0;
                r_eot_rd <= 1'b0;
                r_eot_wr <= 1'b0;
            end else if (w_clr) begin
                r_rd     <= '0;
                r_wr     <= '0;
                r_cnt    <= '0;
                r_last   <= 1'b0;
                r_ovf    <= 1'b0;
                r_udf    <= 1'b0;
                r_eot_rd <= 1'b0;
                r_eot_wr <= 1'b0;
            end else begin
                r_eot_rd <= w_eot & w_ev;
                r_eot_wr <= w_eot & ~w_ev;
                if (w_push)
                    r_last <= w_tag;
                if (w_eot & w_empty & ~w_push)
                    r_udf <= 1'b1;
                if (w_push & w_full & ~w_eot)
                    r_ovf <= 1'b1;
                if (w_store) begin
                    r_fifo[r_wr] <= w_tag;
                    r_wr         <= r_wr + 1'b1;
                end
                if (w_pop)
                    r_rd <= r_rd + 1'b1;
                if (w_store & ~w_pop)
                    r_cnt <= r_cnt + 1'b1;
                else if (w_pop & ~w_store)
                    r_cnt <= r_cnt - 1'b1;
            end
        end

        assign bus.eot_rd_o[c]  = r_eot_rd;
        assign bus.eot_wr_o[c]  = r_eot_wr;
        assign bus.pending_o[c] = r_cnt;
        assign bus.ovf_o[c]     = r_ovf;
        assign bus.udf_o[c]     = r_udf;
    end
endmodule

// File: tb/tb_udma_hyper_eot_tracker.sv
// Randomised and directed bench for udma_hyper_eot_tracker against a
// queue-based direction model.
module tb_udma_hyper_eot_tracker;
    localparam int NB_CH = 2;
    localparam int DEPTH = 4;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic clk;
    logic rstn;
    int   total = 0;
    int   bad   = 0;

    udma_hyper_eot_tracker_if #(.NB_CH(NB_CH), .DEPTH(DEPTH), .CNT_W(CNT_W)) ifc ();

    udma_hyper_eot_tracker #(.NB_CH(NB_CH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .sys_clk_i (clk),
        .rstn_i    (rstn),
        .bus       (ifc.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: queue of directions per channel (1 = read)
    bit mq [NB_CH][$];
    bit mlast [NB_CH];
    bit movf  [NB_CH];
    bit mudf  [NB_CH];
    bit mrd   [NB_CH];
    bit mwr   [NB_CH];

    task automatic model_reset();
        for (int c = 0; c < NB_CH; c++) begin
            mq[c].delete();
            mlast[c] = 0; movf[c] = 0; mudf[c] = 0;
            mrd[c] = 0; mwr[c] = 0;
        end
    endtask

    task automatic model_step(input logic [NB_CH-1:0] rx, tx, eot, clr);
        bit push, tag, ev;
        for (int c = 0; c < NB_CH; c++) begin
            mrd[c] = 0;
            mwr[c] = 0;
            if (clr[c]) begin
                mq[c].delete();
                mlast[c] = 0; movf[c] = 0; mudf[c] = 0;
                continue;
            end
            push = rx[c] || tx[c];
            tag  = (rx[c] && tx[c]) ? mlast[c] : rx[c];
            if (eot[c]) begin
                if (mq[c].size() > 0) begin
                    ev = mq[c].pop_front();
                    if (push) mq[c].push_back(tag);
                end else if (push) begin
                    ev = tag;
                end else begin
                    ev = mlast[c];
                    mudf[c] = 1;
                end
                mrd[c] = ev;
                mwr[c] = !ev;
            end else if (push) begin
                if (mq[c].size() == DEPTH) movf[c] = 1;
                else mq[c].push_back(tag);
            end
            if (push) mlast[c] = tag;
        end
    endtask

    task automatic tick(input logic [NB_CH-1:0] rx, tx, eot, clr);
        @(negedge clk);
        ifc.rx_evt_i = rx;
        ifc.tx_evt_i = tx;
        ifc.eot_i    = eot;
        ifc.clr_i    = clr;
        @(posedge clk);
        model_step(rx, tx, eot, clr);
        #1;
    endtask

    task automatic test_reset();
        ifc.rx_evt_i = '0; ifc.tx_evt_i = '0;
        ifc.eot_i = '0; ifc.clr_i = '0;
        rstn = 1'b0;
        #12;
        total++;
        if ({ifc.eot_rd_o, ifc.eot_wr_o, ifc.ovf_o, ifc.udf_o, ifc.pending_o} !== '0) begin
            bad++;
            $display("FAIL reset_hold: got rd=%b wr=%b ovf=%b udf=%b pend=%h want all 0",
                     ifc.eot_rd_o, ifc.eot_wr_o, ifc.ovf_o, ifc.udf_o, ifc.pending_o);
        end
        @(negedge clk);
        rstn = 1'b1;
        model_reset();
        tick('0, '0, '0, '0);
        total++;
        if ({ifc.eot_rd_o, ifc.eot_wr_o, ifc.ovf_o, ifc.udf_o, ifc.pending_o} !== '0) begin
            bad++;
            $display("FAIL reset_idle: got rd=%b wr=%b ovf=%b udf=%b pend=%h want all 0",
                     ifc.eot_rd_o, ifc.eot_wr_o, ifc.ovf_o, ifc.udf_o, ifc.pending_o);
        end
    endtask

    task automatic test_ordering();
        logic [NB_CH-1:0] rx_seq [3];
        logic [NB_CH-1:0] tx_seq [3];
        rx_seq = '{2'b01, 2'b00, 2'b01};
        tx_seq = '{2'b00, 2'b01, 2'b00};
        tick('0, '0, '0, 2'b11);
        for (int i = 0; i < 3; i++) begin
            tick(rx_seq[i], tx_seq[i], '0, '0);
            total++;
            if (ifc.pending_o[0] !== CNT_W'(i + 1)) begin
                bad++;
                $display("FAIL order_fill%0d: pending=%0d want %0d", i, ifc.pending_o[0], i + 1);
            end
        end
        for (int i = 0; i < 3; i++) begin
            tick('0, '0, 2'b01, '0);
            total++;
            if ({ifc.eot_rd_o[0], ifc.eot_wr_o[0], ifc.pending_o[0]} !==
                {mrd[0], mwr[0], CNT_W'(2 - i)} || mrd[0] !== rx_seq[i][0]) begin
                bad++;
                $display("FAIL order_pop%0d: rd=%b wr=%b pend=%0d want rd=%b wr=%b pend=%0d",
                         i, ifc.eot_rd_o[0], ifc.eot_wr_o[0], ifc.pending_o[0],
                         mrd[0], mwr[0], 2 - i);
            end
        end
        tick('0, '0, '0, '0);
        total++;
        if ({ifc.eot_rd_o[0], ifc.eot_wr_o[0]} !== 2'b00) begin
            bad++;
            $display("FAIL order_pulse_width: rd=%b wr=%b want 0 0",
                     ifc.eot_rd_o[0], ifc.eot_wr_o[0]);
        end
    endtask

    task automatic test_overflow();
        tick('0, '0, '0, 2'b01);
        for (int i = 0; i < 5; i++) tick('0, 2'b01, '0, '0);
        total++;
        if ({ifc.pending_o[0], ifc.ovf_o[0]} !== {CNT_W'(DEPTH), 1'b1}) begin
            bad++;
            $display("FAIL ovf_full: pending=%0d ovf=%b want %0d 1",
                     ifc.pending_o[0], ifc.ovf_o[0], DEPTH);
        end
        for (int i = 0; i < DEPTH; i++) begin
            tick('0, '0, 2'b01, '0);
            total++;
            if ({ifc.eot_rd_o[0], ifc.eot_wr_o[0]} !== 2'b01) begin
                bad++;
                $display("FAIL ovf_drain%0d: rd=%b wr=%b want 0 1",
                         i, ifc.eot_rd_o[0], ifc.eot_wr_o[0]);
            end
        end
        total++;
        if ({ifc.pending_o[0], ifc.ovf_o[0]} !== {CNT_W'(0), 1'b1}) begin
            bad++;
            $display("FAIL ovf_empty: pending=%0d ovf=%b want 0 1",
                     ifc.pending_o[0], ifc.ovf_o[0]);
        end
    endtask

    task automatic test_underflow_bypass();
        tick('0, '0, '0, 2'b01);
        tick('0, '0, 2'b01, '0);
        total++;
        if ({ifc.eot_rd_o[0], ifc.eot_wr_o[0], ifc.udf_o[0]} !== 3'b011) begin
            bad++;
            $display("FAIL underflow: rd=%b wr=%b udf=%b want 0 1 1",
                     ifc.eot_rd_o[0], ifc.eot_wr_o[0], ifc.udf_o[0]);
        end
        tick('0, '0, '0, 2'b01);
        tick(2'b01, '0, 2'b01, '0);
        total++;
        if ({ifc.eot_rd_o[0], ifc.eot_wr_o[0], ifc.udf_o[0], ifc.pending_o[0]} !==
            {3'b100, CNT_W'(0)}) begin
            bad++;
            $display("FAIL bypass: rd=%b wr=%b udf=%b pend=%0d want 1 0 0 0",
                     ifc.eot_rd_o[0], ifc.eot_wr_o[0], ifc.udf_o[0], ifc.pending_o[0]);
        end
    endtask

    task automatic test_full_pushpop();
        bit want [4];
        want = '{1, 0, 0, 0};
        tick('0, '0, '0, 2'b01);
        tick(2'b01, '0, '0, '0);
        tick(2'b01, '0, '0, '0);
        tick('0, 2'b01, '0, '0);
        tick('0, 2'b01, '0, '0);
        tick('0, 2'b01, 2'b01, '0);
        total++;
        if ({ifc.eot_rd_o[0], ifc.eot_wr_o[0], ifc.ovf_o[0], ifc.pending_o[0]} !==
            {3'b100, CNT_W'(DEPTH)}) begin
            bad++;
            $display("FAIL full_pushpop: rd=%b wr=%b ovf=%b pend=%0d want 1 0 0 %0d",
                     ifc.eot_rd_o[0], ifc.eot_wr_o[0], ifc.ovf_o[0], ifc.pending_o[0], DEPTH);
        end
        for (int i = 0; i < 4; i++) begin
            tick('0, '0, 2'b01, '0);
            total++;
            if ({ifc.eot_rd_o[0], ifc.eot_wr_o[0]} !== {want[i], !want[i]}) begin
                bad++;
                $display("FAIL full_drain%0d: rd=%b wr=%b want rd=%b",
                         i, ifc.eot_rd_o[0], ifc.eot_wr_o[0], want[i]);
            end
        end
    endtask

    task automatic test_random();
        logic [NB_CH-1:0] rx, tx, eot, clr;
        tick('0, '0, '0, 2'b11);
        for (int n = 0; n < 300; n++) begin
            rx  = NB_CH'($urandom_range(0, 3));
            tx  = NB_CH'($urandom_range(0, 3));
            eot = NB_CH'($urandom_range(0, 3));
            clr = '0;
            if ($urandom_range(0, 31) == 0) clr[0] = 1'b1;
            if ($urandom_range(0, 31) == 0) clr[1] = 1'b1;
            if (n == 150) begin
                clr[1] = 1'b1;
                eot[1] = 1'b1;
            end
            tick(rx, tx, eot, clr);
            for (int c = 0; c < NB_CH; c++) begin
                total++;
                if ({ifc.eot_rd_o[c], ifc.eot_wr_o[c], ifc.ovf_o[c], ifc.udf_o[c],
                     ifc.pending_o[c]} !==
                    {mrd[c], mwr[c], movf[c], mudf[c], CNT_W'(mq[c].size())}) begin
                    bad++;
                    $display("FAIL rand_c%0d_n%0d: rd=%b wr=%b ovf=%b udf=%b pend=%0d want %b %b %b %b %0d",
                             c, n, ifc.eot_rd_o[c], ifc.eot_wr_o[c], ifc.ovf_o[c],
                             ifc.udf_o[c], ifc.pending_o[c], mrd[c], mwr[c],
                             movf[c], mudf[c], mq[c].size());
                end
            end
            if (n == 150) begin
                total++;
                if ({ifc.eot_rd_o[1], ifc.eot_wr_o[1], ifc.pending_o[1]} !==
                    {2'b00, CNT_W'(0)}) begin
                    bad++;
                    $display("FAIL clr_ch1: rd=%b wr=%b pend=%0d want 0 0 0",
                             ifc.eot_rd_o[1], ifc.eot_wr_o[1], ifc.pending_o[1]);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        tick('0, '0, '0, 2'b01);
        tick(2'b01, '0, '0, '0);
        tick('0, 2'b01, '0, '0);
        tick(2'b01, '0, 2'b10, '0);
        @(negedge clk);
        ifc.rx_evt_i = '0; ifc.tx_evt_i = '0;
        ifc.eot_i = '0; ifc.clr_i = '0;
        #2 rstn = 1'b0;
        #1;
        total++;
        if ({ifc.eot_rd_o, ifc.eot_wr_o, ifc.ovf_o, ifc.udf_o, ifc.pending_o} !== '0) begin
            bad++;
            $display("FAIL reset_mid: rd=%b wr=%b ovf=%b udf=%b pend=%h want all 0",
                     ifc.eot_rd_o, ifc.eot_wr_o, ifc.ovf_o, ifc.udf_o, ifc.pending_o);
        end
        @(negedge clk);
        rstn = 1'b1;
        model_reset();
        tick('0, '0, 2'b01, '0);
        total++;
        if ({ifc.eot_rd_o[0], ifc.eot_wr_o[0], ifc.udf_o[0], ifc.pending_o[0]} !==
            {3'b011, CNT_W'(0)}) begin
            bad++;
            $display("FAIL reset_after: rd=%b wr=%b udf=%b pend=%0d want 0 1 1 0",
                     ifc.eot_rd_o[0], ifc.eot_wr_o[0], ifc.udf_o[0], ifc.pending_o[0]);
        end
    endtask

    initial begin
        rstn = 1'b0;
        model_reset();
        test_reset();
        test_ordering();
        test_overflow();
        test_underflow_bypass();
        test_full_pushpop();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
